// File: rtl/xbar_config_loader_pkg.sv
// Shared constants, state encoding and field helper for the crossbar
// configuration loader and its range checker.
package xbar_cfg_pkg;

    localparam int NUM_IN    = 27;
    localparam int NUM_OUT   = 35;
    localparam int SEL_W     = 5;
    localparam int CFG_W     = NUM_OUT * SEL_W;
    localparam int WORD_W    = 8;
    localparam int NUM_WORDS = (CFG_W + WORD_W - 1) / WORD_W;
    localparam int CNT_W     = $clog2(NUM_WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_CHECK  = 2'd2,
        S_COMMIT = 2'd3
    } state_e;

    function automatic logic [SEL_W-1:0] cfg_field(input logic [CFG_W-1:0] cfg, input int k);
        return cfg[k*SEL_W +: SEL_W];
    endfunction

endpackage

// File: rtl/xbar_config_loader_if.sv
// Control, byte-stream and configuration signals between the tile
// configuration controller (master) and the loader (slave).
interface xbar_config_loader_if;
    import xbar_cfg_pkg::*;

    logic               start;
    logic               abort;
    logic               cfg_in_valid;
    logic               cfg_in_ready;
    logic [WORD_W-1:0]  cfg_in_bits;
    logic [CFG_W-1:0]   mux_configs;
    logic               busy;
    logic               done;
    logic               error;
    logic [NUM_OUT-1:0] field_illegal;

    modport master (
        output start, abort, cfg_in_valid, cfg_in_bits,
        input  cfg_in_ready, mux_configs, busy, done, error, field_illegal
    );

    modport slave (
        input  start, abort, cfg_in_valid, cfg_in_bits,
        output cfg_in_ready, mux_configs, busy, done, error, field_illegal
    );

endinterface

// File: rtl/xbar_cfg_checker.sv
// Combinational range check of every select field in a packed crossbar
// configuration; flags each field that selects a non-existent input.
module xbar_cfg_checker
    import xbar_cfg_pkg::*;
(
    input  logic [CFG_W-1:0]   cfg,
    output logic [NUM_OUT-1:0] field_illegal,
    output logic               any_illegal
);

    // Compare one bit wider so the bound stays correct even if NUM_IN == 2**SEL_W.
    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            field_illegal[k] = ({1'b0, cfg_field(cfg, k)} >= (SEL_W + 1)'(NUM_IN));
        end
    end

    assign any_illegal = |field_illegal;

endmodule

// File: rtl/xbar_config_loader.sv
// Assembles a byte stream into a shadow configuration, range-checks it and
// commits it atomically to the registered crossbar select bus.
module xbar_config_loader
    import xbar_cfg_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    xbar_config_loader_if.slave io
);

    localparam logic [1:0] IDLE   = S_IDLE;
    localparam logic [1:0] LOAD   = S_LOAD;
    localparam logic [1:0] CHECK  = S_CHECK;
    localparam logic [1:0] COMMIT = S_COMMIT;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [CFG_W-1:0]   shadow;
    logic [CFG_W-1:0]   shadow_next;
    logic [CFG_W-1:0]   active;
    logic               error_q;
    logic               handshake;
    logic               any_illegal;
    logic [NUM_OUT-1:0] field_illegal;

    xbar_cfg_checker u_checker (
        .cfg           (shadow),
        .field_illegal (field_illegal),
        .any_illegal   (any_illegal)
    );

    assign handshake = io.cfg_in_valid && io.cfg_in_ready;

    // Bits of the last word that fall beyond CFG_W have no destination and drop out here.
    // NOTE: start from the current value so every path assigns shadow_next; no latch is inferred.
    always_comb begin
        shadow_next = shadow;
        for (int b = 0; b < CFG_W; b++) begin
            if (cnt == CNT_W'(b / WORD_W)) begin
                shadow_next[b] = io.cfg_in_bits[b % WORD_W];
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: shadow and active are plain flops, not a RAM, so they take the async reset too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            shadow  <= '0;
            active  <= '0;
            error_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.start) begin
                        state   <= LOAD;
                        cnt     <= '0;
                        shadow  <= '0;
                        error_q <= 1'b0;
                    end
                end
                LOAD: begin
                    // Abort outranks a coincident handshake: the word is dropped.
                    if (io.abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (handshake) begin
                        shadow <= shadow_next;
                        if (cnt == LAST_WORD) begin
                            state <= CHECK;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (io.abort) begin
                        state <= IDLE;
                    end else if (any_illegal) begin
                        error_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    active <= shadow;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.cfg_in_ready  = (state == LOAD);
    assign io.busy          = (state != IDLE);
    assign io.done          = (state == COMMIT);
    assign io.error         = error_q;
    assign io.mux_configs   = active;
    assign io.field_illegal = field_illegal;

endmodule
